// File: rtl/inv_substitution_seq.sv
// rtl/inv_substitution_seq.sv - iterative inverse Ascon S-box layer over the 320-bit state
module inv_substitution_seq #(
  parameter int COLS_PER_CYCLE = 8
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic             enable_i,
  input  logic [0:4][63:0] state_i,
  output logic [0:4][63:0] state_o,
  output logic             busy_o,
  output logic             done_o
);

  // Number of slices per pass and the width of the slice counter (never below 1 bit).
  localparam int N     = 64 / COLS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           fsm;
  state_t           fsm_next;
  logic [CNT_W-1:0] cnt;
  logic [0:4][63:0] work;
  logic [0:4][63:0] work_next;
  logic             last_slice;
  logic [5:0]       col;
  logic [4:0]       sbox_in;
  logic [4:0]       sbox_out;

  // Inverse of the Ascon 5-bit S-box; bit 4 corresponds to word 0.
  function automatic logic [4:0] inv_sbox(input logic [4:0] x);
    case (x)
      5'h00: return 5'h14;  5'h01: return 5'h1a;  5'h02: return 5'h07;  5'h03: return 5'h0d;
      5'h04: return 5'h00;  5'h05: return 5'h09;  5'h06: return 5'h0e;  5'h07: return 5'h12;
      5'h08: return 5'h0a;  5'h09: return 5'h06;  5'h0a: return 5'h1d;  5'h0b: return 5'h01;
      5'h0c: return 5'h19;  5'h0d: return 5'h15;  5'h0e: return 5'h13;  5'h0f: return 5'h1e;
      5'h10: return 5'h18;  5'h11: return 5'h16;  5'h12: return 5'h0b;  5'h13: return 5'h11;
      5'h14: return 5'h03;  5'h15: return 5'h05;  5'h16: return 5'h1c;  5'h17: return 5'h1f;
      5'h18: return 5'h17;  5'h19: return 5'h1b;  5'h1a: return 5'h04;  5'h1b: return 5'h08;
      5'h1c: return 5'h0f;  5'h1d: return 5'h0c;  5'h1e: return 5'h10;  default: return 5'h02;
    endcase
  endfunction

  assign last_slice = (cnt == LAST);
  assign state_o    = work;

  // FSM state register.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  // Next-state logic; DONE accepts a new start directly for back-to-back runs.
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (start_i) fsm_next = RUN;
      RUN:     if (enable_i && last_slice) fsm_next = DONE;
      DONE:    fsm_next = start_i ? RUN : IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // Invert the current slice of COLS_PER_CYCLE columns across all five words.
  always_comb begin
    work_next = work;
    col       = '0;
    sbox_in   = '0;
    sbox_out  = '0;
    for (int c = 0; c < COLS_PER_CYCLE; c++) begin
      col      = 6'(int'(cnt) * COLS_PER_CYCLE + c);
      sbox_in  = {work[0][col], work[1][col], work[2][col], work[3][col], work[4][col]};
      sbox_out = inv_sbox(sbox_in);
      work_next[0][col] = sbox_out[4];
      work_next[1][col] = sbox_out[3];
      work_next[2][col] = sbox_out[2];
      work_next[3][col] = sbox_out[1];
      work_next[4][col] = sbox_out[0];
    end
  end

  // Work register and slice counter; starts are only honoured outside RUN.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      work <= '0;
      cnt  <= '0;
    end else if (fsm != RUN) begin
      if (start_i) begin
        work <= state_i;
        cnt  <= '0;
      end
    end else if (enable_i) begin
      work <= work_next;
      cnt  <= last_slice ? '0 : cnt + CNT_W'(1);
    end
  end

  // Registered status flags, derived from the state being entered.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      busy_o <= (fsm_next == RUN);
      done_o <= (fsm_next == DONE);
    end
  end

endmodule

// File: tb/tb_inv_substitution_seq.sv
// tb/tb_inv_substitution_seq.sv - self-checking bench for inv_substitution_seq
module tb_inv_substitution_seq;

  typedef logic [0:4][63:0] st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb;
  logic start;
  logic enable;
  st_t  state_in;
  st_t  q8, q1, q64;
  logic busy8, busy1, busy64;
  logic done8, done1, done64;

  inv_substitution_seq #(.COLS_PER_CYCLE(8)) dut8 (
    .clock_i(clk), .resetb_i(resetb), .start_i(start), .enable_i(enable),
    .state_i(state_in), .state_o(q8), .busy_o(busy8), .done_o(done8)
  );
  inv_substitution_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clock_i(clk), .resetb_i(resetb), .start_i(start), .enable_i(enable),
    .state_i(state_in), .state_o(q1), .busy_o(busy1), .done_o(done1)
  );
  inv_substitution_seq #(.COLS_PER_CYCLE(64)) dut64 (
    .clock_i(clk), .resetb_i(resetb), .start_i(start), .enable_i(enable),
    .state_i(state_in), .state_o(q64), .busy_o(busy64), .done_o(done64)
  );

  int compared   = 0;
  int mismatched = 0;

  int inv_tab[32] = '{'h14, 'h1a, 'h07, 'h0d, 'h00, 'h09, 'h0e, 'h12,
                      'h0a, 'h06, 'h1d, 'h01, 'h19, 'h15, 'h13, 'h1e,
                      'h18, 'h16, 'h0b, 'h11, 'h03, 'h05, 'h1c, 'h1f,
                      'h17, 'h1b, 'h04, 'h08, 'h0f, 'h0c, 'h10, 'h02};
  int fwd_tab[32];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply a 32-entry table to every column; word 0 is the MSB of the column index.
  function automatic st_t apply_table(input st_t s, input bit forward);
    st_t r;
    int  idx;
    int  v;
    for (int col = 0; col < 64; col++) begin
      idx = 0;
      for (int w = 0; w < 5; w++) idx = idx * 2 + int'(s[w][col]);
      v = forward ? fwd_tab[idx] : inv_tab[idx];
      for (int w = 0; w < 5; w++) r[w][col] = v[4-w];
    end
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t r;
    for (int w = 0; w < 5; w++) r[w] = {$urandom(), $urandom()};
    return r;
  endfunction

  // One run on the C=8 unit; prob is the percentage chance of stalling each RUN cycle.
  task automatic run8(input st_t s, input int prob, output st_t res, output int edges, output int stalls);
    bit en;
    state_in = s;
    start    = 1'b1;
    tick();
    start  = 1'b0;
    edges  = 1;
    stalls = 0;
    check("busy_after_start", busy8, 1'b1);
    while (!done8 && edges < 300) begin
      en     = ($urandom_range(0, 99) < prob) ? 1'b0 : 1'b1;
      enable = en;
      tick();
      edges++;
      if (!en) stalls++;
    end
    enable = 1'b1;
    check("done_seen", done8, 1'b1);
    check("busy_low_in_done", busy8, 1'b0);
    res = q8;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    st_t res, a, b, r1, r2;
    int  edges, stalls, pulses, first;
    int  d8, d1, d64;
    st_t r8, r1c, r64;

    for (int i = 0; i < 32; i++) fwd_tab[inv_tab[i]] = i;

    resetb   = 1'b0;
    start    = 1'b0;
    enable   = 1'b1;
    state_in = '0;
    tick();
    tick();
    check("reset_state", q8, '0);
    check("reset_busy", busy8, 1'b0);
    check("reset_done", done8, 1'b0);
    resetb = 1'b1;
    tick();

    // All-zero input.
    run8('0, 0, res, edges, stalls);
    check("zero_latency", edges, 9);
    check("zero_result", res, {ONES, 64'h0, ONES, 64'h0, 64'h0});

    // All-ones input on C=8, C=1 and C=64 together.
    resetb = 1'b0;
    tick();
    resetb   = 1'b1;
    state_in = {ONES, ONES, ONES, ONES, ONES};
    start    = 1'b1;
    tick();
    start = 1'b0;
    d8 = 0; d1 = 0; d64 = 0;
    r8 = '0; r1c = '0; r64 = '0;
    for (int e = 1; e <= 80; e++) begin
      if (done8 && d8 == 0) begin d8 = e; r8 = q8; end
      if (done1 && d1 == 0) begin d1 = e; r1c = q1; end
      if (done64 && d64 == 0) begin d64 = e; r64 = q64; end
      tick();
    end
    check("ones_lat_c8", d8, 9);
    check("ones_lat_c1", d1, 65);
    check("ones_lat_c64", d64, 2);
    check("ones_res_c8", r8, {64'h0, 64'h0, 64'h0, ONES, 64'h0});
    check("ones_res_c1", r1c, {64'h0, 64'h0, 64'h0, ONES, 64'h0});
    check("ones_res_c64", r64, {64'h0, 64'h0, 64'h0, ONES, 64'h0});

    // Round trip of the reference vectors, second one issued in the DONE cycle.
    a = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaa0f,
         64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};
    b = {64'ha71b22fa2d0f5150, 64'hb11e0a9a608e0016, 64'h076f27ad4d99d506,
         64'ha72ac1ad8440b0b7, 64'h0657b0d6eaf9c1c4};
    run8(apply_table(a, 1'b1), 0, res, edges, stalls);
    check("rt_a_result", res, a);
    run8(apply_table(b, 1'b1), 0, res, edges, stalls);
    check("rt_b_latency", edges, 9);
    check("rt_b_result", res, b);
    tick();

    // Three stall cycles mid-RUN.
    r1       = rand_state();
    state_in = r1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    repeat (3) begin tick(); edges++; end
    enable = 1'b0;
    repeat (3) begin tick(); edges++; end
    check("busy_during_stall", busy8, 1'b1);
    enable = 1'b1;
    while (!done8 && edges < 300) begin tick(); edges++; end
    check("stall_latency", edges, 12);
    check("stall_result", q8, apply_table(r1, 1'b0));
    tick();

    // start pulse with a different state during RUN is ignored.
    r1       = rand_state();
    r2       = rand_state();
    state_in = r1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    state_in = r2;
    start    = 1'b1;
    tick();
    start  = 1'b0;
    pulses = 0;
    first  = 0;
    res    = '0;
    for (int e = 4; e <= 24; e++) begin
      if (done8) begin
        pulses++;
        if (first == 0) begin first = e; res = q8; end
      end
      tick();
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_latency", first, 9);
    check("ignore_result", res, apply_table(r1, 1'b0));
    check("result_held", q8, apply_table(r1, 1'b0));

    // Asynchronous reset at slice 4 of 8.
    state_in = rand_state();
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    resetb = 1'b0;
    #1;
    check("async_rst_state", q8, '0);
    check("async_rst_busy", busy8, 1'b0);
    check("async_rst_done", done8, 1'b0);
    tick();
    resetb = 1'b1;
    pulses = 0;
    repeat (12) begin
      tick();
      if (done8 || busy8) pulses++;
    end
    check("no_activity_after_rst", pulses, 0);
    r1 = rand_state();
    run8(r1, 0, res, edges, stalls);
    check("post_rst_result", res, apply_table(r1, 1'b0));

    // Randomized runs with random stalls, plus round trips.
    for (int k = 0; k < 6; k++) begin
      r1 = rand_state();
      run8(r1, 30, res, edges, stalls);
      check("rand_latency", edges, 9 + stalls);
      check("rand_result", res, apply_table(r1, 1'b0));
      run8(apply_table(r1, 1'b1), 20, res, edges, stalls);
      check("rand_roundtrip", res, r1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
